// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one request at a time, fixed latency, then a
// byte/half-word/word access to an internal word-organised RAM with load extension.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned IdxW  = ADDR_WIDTH - 2;
    localparam int unsigned Depth = 2 ** IdxW;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state;
    logic [3:0]  cnt;
    logic        we_l;
    logic [31:0] addr_l;
    logic [1:0]  size_l;
    logic        sign_l;
    logic [31:0] wdata_l;

    logic [31:0] mem [Depth];

    logic            acc_we;
    logic [31:0]     acc_addr;
    logic [1:0]      acc_size;
    logic            acc_sign;
    logic [31:0]     acc_wdata;
    logic [IdxW-1:0] acc_idx;
    logic            acc_err;
    logic [3:0]      acc_be;
    logic [31:0]     acc_wd;
    logic [31:0]     acc_rdata;
    logic [31:0]     word;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            access;

    // With zero latency the access happens on the accepting edge, so use the live request.
    always_comb begin
        if (state == StIdle) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_size  = req_size;
            acc_sign  = req_sign;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_l;
            acc_addr  = addr_l;
            acc_size  = size_l;
            acc_sign  = sign_l;
            acc_wdata = wdata_l;
        end
    end

    assign acc_idx = acc_addr[ADDR_WIDTH-1:2];
    assign access  = rst && ((state == StIdle && req_valid && LATENCY == 0) ||
                             (state == StWait && cnt == 4'd0));

    always_comb begin
        acc_err   = 1'b0;
        acc_be    = 4'b0000;
        acc_wd    = 32'd0;
        acc_rdata = 32'd0;
        word      = mem[acc_idx];
        byte_v    = word[{acc_addr[1:0], 3'b000} +: 8];
        half_v    = acc_addr[1] ? word[31:16] : word[15:0];
        case (acc_size)
            2'b00: begin
                acc_be    = 4'b0001 << acc_addr[1:0];
                acc_wd    = {4{acc_wdata[7:0]}};
                acc_rdata = {{24{acc_sign & byte_v[7]}}, byte_v};
            end
            2'b01: begin
                acc_err   = acc_addr[0];
                acc_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
                acc_wd    = {2{acc_wdata[15:0]}};
                acc_rdata = {{16{acc_sign & half_v[15]}}, half_v};
            end
            2'b10: begin
                acc_err   = |acc_addr[1:0];
                acc_be    = 4'b1111;
                acc_wd    = acc_wdata;
                acc_rdata = word;
            end
            default: acc_err = 1'b1;
        endcase
        if ((acc_addr >> ADDR_WIDTH) != 32'd0) begin
            acc_err = 1'b1;
        end
        if (acc_err || acc_we) begin
            acc_rdata = 32'd0;
        end
    end

    // RAM is deliberately left out of reset so its contents survive it.
    always_ff @(posedge clk) begin
        if (access && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wd[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            we_l      <= 1'b0;
            addr_l    <= 32'd0;
            size_l    <= 2'b00;
            sign_l    <= 1'b0;
            wdata_l   <= 32'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        we_l      <= req_we;
                        addr_l    <= req_addr;
                        size_l    <= req_size;
                        sign_l    <= req_sign;
                        wdata_l   <= req_wdata;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= acc_rdata;
                            rsp_err   <= acc_err;
                        end else begin
                            state <= StWait;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                StWait: begin
                    if (cnt == 4'd0) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= acc_rdata;
                        rsp_err   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written reset/backpressure
// sequences and randomized traffic checked against a byte-addressed memory model.
module tb_dmem_responder;
    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(17), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] ref_bytes [int unsigned];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: a sparse byte memory; sign extension done arithmetically.
    task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sign, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er);
        int unsigned n;
        longint v;
        n  = 1 << size;
        er = (size == 2'b11) || ((addr % n) != 0) || (addr >= 32'h0002_0000);
        rd = 32'd0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < int'(n); i++) ref_bytes[addr + i] = wdata[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < int'(n); i++) v = v + (longint'(ref_bytes[addr + i]) << (8*i));
                if (sign && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
                rd = v[31:0];
            end
        end
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sign, input logic [31:0] wdata, input int hold,
                       output logic [31:0] rd, output logic er);
        int guard;
        int lat;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_sign = sign; req_wdata = wdata;
        @(posedge clk); #1;
        chk("ready_after_accept", 32'(req_ready), 32'd0);
        // inputs after acceptance must be ignored
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_size = 2'($urandom); req_sign = 1'($urandom); req_wdata = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(LAT));
        rd = rsp_rdata;
        er = rsp_err;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_we = 1'($urandom); req_addr = $urandom;
            req_size = 2'($urandom); req_wdata = $urandom;
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_err", 32'(rsp_err), 32'(er));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("back_to_idle", 32'(req_ready), 32'd1);
    endtask

    task automatic run(input string name, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic sign, input logic [31:0] wdata,
                       input int hold);
        logic [31:0] erd, grd;
        logic        eer, ger;
        model(we, addr, size, sign, wdata, erd, eer);
        txn(we, addr, size, sign, wdata, hold, grd, ger);
        chk({name, "_rdata"}, grd, erd);
        chk({name, "_err"}, 32'(ger), 32'(eer));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] grd, erd, addr;
        logic        ger, eer;

        vecs.push_back('{1'b1, 32'h100,   2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h100,   2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h103,   2'd0, 1'b0, 32'h12345680, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h103,   2'd0, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 32'h103,   2'd0, 1'b0, 32'h0,        32'h00000080, 1'b0});
        vecs.push_back('{1'b0, 32'h100,   2'd2, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h102,   2'd1, 1'b1, 32'h0,        32'hFFFF80AD, 1'b0});
        vecs.push_back('{1'b0, 32'h101,   2'd1, 1'b0, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h102,   2'd2, 1'b0, 32'h11111111, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h100,   2'd3, 1'b0, 32'h22222222, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h20000, 2'd2, 1'b0, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h20100, 2'd2, 1'b0, 32'h33333333, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h101,   2'd1, 1'b0, 32'h44444444, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h100,   2'd2, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h100,   2'd1, 1'b0, 32'h0,        32'h0000BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h101,   2'd0, 1'b1, 32'h0,        32'hFFFFFFBE, 1'b0});
        vecs.push_back('{1'b1, 32'h100,   2'd1, 1'b0, 32'hCAFE1234, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h100,   2'd2, 1'b0, 32'h0,        32'h80AD1234, 1'b0});
        vecs.push_back('{1'b0, 32'h102,   2'd1, 1'b0, 32'h0,        32'h000080AD, 1'b0});

        // Reset state
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sign, vecs[i].wdata, erd, eer);
            txn(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sign, vecs[i].wdata, i % 3,
                grd, ger);
            chk($sformatf("vec%0d_rdata", i), grd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(ger), 32'(vecs[i].exp_err));
        end

        // Asynchronous reset while a response is pending
        model(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, erd, eer);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_sign = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("pend_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pend_rsp_rdata", rsp_rdata, erd);
        #2 rst = 1'b0;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rsp_rdata", rsp_rdata, 32'd0);
        chk("async_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Reset during WAIT drops the store
        run("pre200", 1'b1, 32'h200, 2'd2, 1'b0, 32'hA5A5A5A5, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_size = 2'd2;
        req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("midwait_req_ready", 32'(req_ready), 32'd1);
        chk("midwait_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run("post200", 1'b0, 32'h200, 2'd2, 1'b0, 32'h0, 1);

        // Backpressure with a waiting request, then rsp_ready already high
        model(1'b0, 32'h102, 2'd1, 1'b1, 32'h0, erd, eer);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h102; req_size = 2'd1; req_sign = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'h100; req_size = 2'd2; req_sign = 1'b0; req_we = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rsp_rdata", rsp_rdata, erd);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_rdata", rsp_rdata, erd);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_handshake_valid", 32'(rsp_valid), 32'd0);
        chk("bp_handshake_ready", 32'(req_ready), 32'd1);
        model(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, erd, eer);
        @(posedge clk); #1;
        chk("bp_next_accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rr_rsp_rdata", rsp_rdata, erd);
        @(posedge clk); #1;
        chk("rr_done", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Randomized traffic against the model
        for (int w = 0; w < 16; w++) begin
            run("init", 1'b1, 32'h100 + 32'(4*w), 2'd2, 1'b0, $urandom, 0);
        end
        for (int k = 0; k < 150; k++) begin
            addr = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(17, 31));
            run("rnd", 1'($urandom), addr, 2'($urandom), 1'($urandom), $urandom,
                int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
